key_schedule_seq: RTL and testbench

Sequential AES-128 key-schedule engine that generates one round key per clock from a single shared expansion step (4 S-box lookups), replacing the fully unrolled 10-stage combinational schedule. All round keys are held in an internal register file behind a random-access read port with forward or reverse (decryption) ordering. Each key is also streamed out as it is produced. The block sits between the key-load interface and the encrypt/decrypt round datapaths.

---
 rtl/key_schedule_seq.sv | 179 +++++++++++++++++
 tb/tb_key_schedule_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_seq.sv
// key_schedule_seq
// Sequential AES-128 key schedule. One round key is produced per clock by a
// single expansion step built around one SubWord (4 S-box lookups). All
// round keys rk[0..NR] are held in a register file that is read through a
// random-access port in forward or reverse (decrypt) order. Each key is also
// streamed out on rk_out_o as it is produced.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   start_i         single-cycle expansion request (ignored while busy)
//   key_i[127:0]    cipher key, sampled on the start edge
//   busy_o          expansion in progress
//   done_o          one-cycle pulse when rk[NR] is written
//   key_valid_o     register file holds a complete schedule
//   rd_idx_i[3:0]   round-key read index
//   rd_rev_i        1: read rk[NR-rd_idx], 0: read rk[rd_idx]
//   rd_key_o[127:0] selected round key (0 when invalid or out of range)
//   rk_out_o[127:0] round key just produced
//   rk_out_valid_o  rk_out_o qualifier, one cycle per key
//   rk_out_idx_o    index of rk_out_o
module key_schedule_seq #(
    parameter int unsigned NR        = 10,
    parameter logic [7:0]  RCON_INIT = 8'h01
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         key_valid_o,
    input  logic [3:0]   rd_idx_i,
    input  logic         rd_rev_i,
    output logic [127:0] rd_key_o,
    output logic [127:0] rk_out_o,
    output logic         rk_out_valid_o,
    output logic [3:0]   rk_out_idx_o
);

    localparam logic [3:0] NR_L = 4'(NR);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_t        state_q;
    logic [3:0]    ctr_q;
    logic [7:0]    rcon_q;
    logic [127:0]  rk_q [0:NR];
    logic          busy_q;
    logic          done_q;
    logic          key_valid_q;
    logic [127:0]  rk_out_q;
    logic          rk_out_valid_q;
    logic [3:0]    rk_out_idx_q;

    logic [7:0]    rcon_d;
    logic [127:0]  exp_key_d;

    // rk_out_q always holds rk[ctr-1] during EXPAND, so it doubles as the
    // expansion source and no register-file read mux is needed here.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, t;
        w0 = rk_out_q[127:96];
        w1 = rk_out_q[95:64];
        w2 = rk_out_q[63:32];
        w3 = rk_out_q[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
        w4 = w0 ^ t;
        w5 = w1 ^ w4;
        w6 = w2 ^ w5;
        w7 = w3 ^ w6;
        exp_key_d = {w4, w5, w6, w7};
        rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            ctr_q          <= '0;
            rcon_q         <= RCON_INIT;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            key_valid_q    <= 1'b0;
            rk_out_q       <= '0;
            rk_out_valid_q <= 1'b0;
            rk_out_idx_q   <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            done_q         <= 1'b0;
            rk_out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rk_q[0]        <= key_i;
                        ctr_q          <= 4'd1;
                        rcon_q         <= RCON_INIT;
                        key_valid_q    <= 1'b0;
                        busy_q         <= 1'b1;
                        rk_out_q       <= key_i;
                        rk_out_idx_q   <= 4'd0;
                        rk_out_valid_q <= 1'b1;
                        state_q        <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int i = 1; i <= NR; i++) begin
                        if (ctr_q == 4'(i)) begin
                            rk_q[i] <= exp_key_d;
                        end
                    end
                    rk_out_q       <= exp_key_d;
                    rk_out_idx_q   <= ctr_q;
                    rk_out_valid_q <= 1'b1;
                    rcon_q         <= rcon_d;
                    ctr_q          <= ctr_q + 4'd1;
                    if (ctr_q == NR_L) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        key_valid_q <= 1'b1;
                        ctr_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // key_valid is low for the whole expansion, which keeps partially
    // rewritten schedules off the read port.
    always_comb begin
        logic [3:0] eff_idx;
        eff_idx  = rd_rev_i ? (NR_L - rd_idx_i) : rd_idx_i;
        rd_key_o = '0;
        if (key_valid_q && (rd_idx_i <= NR_L)) begin
            for (int i = 0; i <= NR; i++) begin
                if (eff_idx == 4'(i)) begin
                    rd_key_o = rk_q[i];
                end
            end
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign key_valid_o    = key_valid_q;
    assign rk_out_o       = rk_out_q;
    assign rk_out_valid_o = rk_out_valid_q;
    assign rk_out_idx_o   = rk_out_idx_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Testbench for key_schedule_seq. Expected round keys come from a textbook
// word-oriented AES-128 key expansion whose S-box is derived from GF(2^8)
// inversion plus the affine map. The stream output is checked by a monitor
// popping a queue of expected (idx, key) pairs; the read port, timing and
// reset behaviour are checked directly from the main sequence.
module tb_key_schedule_seq;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [3:0]   rd_idx = '0;
    logic         rd_rev = 1'b0;
    logic         busy, done, key_valid, rk_out_valid;
    logic [127:0] rd_key, rk_out;
    logic [3:0]   rk_out_idx;

    always #5 clk = ~clk;

    key_schedule_seq #(.NR(NR), .RCON_INIT(8'h01)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .key_i          (key),
        .busy_o         (busy),
        .done_o         (done),
        .key_valid_o    (key_valid),
        .rd_idx_i       (rd_idx),
        .rd_rev_i       (rd_rev),
        .rd_key_o       (rd_key),
        .rk_out_o       (rk_out),
        .rk_out_valid_o (rk_out_valid),
        .rk_out_idx_o   (rk_out_idx)
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] k;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;
    logic [7:0]   sbox_m [256];
    logic [127:0] m_rk [0:NR];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(x));
            end
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic compute_model(input logic [127:0] k);
        logic [31:0] w [0:4*NR+3];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 4*NR+4; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Stream monitor: every presented key must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rk_out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stream_unexpected: got idx %0d key %h, none expected", rk_out_idx, rk_out);
            end else begin
                e = exp_q.pop_front();
                chk("stream_idx", 128'(rk_out_idx), 128'(e.idx));
                chk("stream_key", rk_out, e.k);
            end
        end
    end

    // Drives start for one edge (E0) and returns at E0+1ns.
    task automatic start_key(input logic [127:0] k);
        key   = k;
        start = 1'b1;
        compute_model(k);
        for (int i = 0; i <= NR; i++) exp_q.push_back('{4'(i), m_rk[i]});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // elapsed: edges already taken since E0. Returns 1ns after the done edge.
    task automatic wait_done(input string name, input int elapsed);
        int n;
        n = elapsed;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (!done) chk({name, "_rd_hidden"}, rd_key, '0);
        end
        chk({name, "_done_edges"}, 128'(n), 128'(NR));
        chk({name, "_done"}, 128'(done), 128'd1);
        chk({name, "_key_valid"}, 128'(key_valid), 128'd1);
        chk({name, "_busy"}, 128'(busy), 128'd0);
    endtask

    task automatic check_reads(input string name);
        logic [127:0] exp;
        for (int rev = 0; rev < 2; rev++) begin
            for (int idx = 0; idx < 16; idx++) begin
                rd_idx = 4'(idx);
                rd_rev = rev[0];
                #1;
                if (idx > NR) exp = '0;
                else exp = (rev != 0) ? m_rk[NR-idx] : m_rk[idx];
                chk(name, rd_key, exp);
            end
        end
    endtask

    task automatic read_one(input string name, input int idx, input bit rev, input logic [127:0] exp);
        rd_idx = 4'(idx);
        rd_rev = rev;
        #1 chk(name, rd_key, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] k;
        build_sbox();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_key_valid", 128'(key_valid), 128'd0);
        chk("rst_rk_out_valid", 128'(rk_out_valid), 128'd0);
        chk("rst_rk_out", rk_out, '0);
        chk("rst_rk_out_idx", 128'(rk_out_idx), 128'd0);
        chk("rst_rd_key", rd_key, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 A.1 schedule
        start_key(FIPS_KEY);
        wait_done("fips", 0);
        read_one("fips_rk1", 1, 1'b0, FIPS_RK1);
        read_one("fips_rk10", 10, 1'b0, FIPS_RK10);
        read_one("fips_rev0", 0, 1'b1, FIPS_RK10);
        read_one("fips_rev10", 10, 1'b1, FIPS_KEY);
        read_one("fips_rev11", 11, 1'b1, '0);
        read_one("fips_fwd15", 15, 1'b0, '0);
        check_reads("fips_reads");
        @(negedge clk);
        #1 chk("fips_stream_drained", 128'(exp_q.size()), 128'd0);

        // start during expansion is ignored
        @(posedge clk);
        #1;
        start_key(FIPS_KEY);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        key   = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ignored", 4);
        read_one("ignored_rk10", 10, 1'b0, FIPS_RK10);
        check_reads("ignored_reads");

        // reset in the middle of an expansion
        @(posedge clk);
        #1;
        start_key({$urandom, $urandom, $urandom, $urandom});
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_rk_out", rk_out, '0);
        chk("midrst_rk_out_valid", 128'(rk_out_valid), 128'd0);
        chk("midrst_rk_out_idx", 128'(rk_out_idx), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_key_valid", 128'(key_valid), 128'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 chk("midrst_no_done", 128'(done), 128'd0);
            if (i == 2) rst_n = 1'b1;
        end
        start_key('0);
        wait_done("zero", 0);
        read_one("zero_rk10", 10, 1'b0, ZERO_RK10);
        check_reads("zero_reads");

        // back-to-back: restart in the cycle right after done
        @(posedge clk);
        #1;
        start_key({$urandom, $urandom, $urandom, $urandom});
        wait_done("b2b_first", 0);
        k = {$urandom, $urandom, $urandom, $urandom};
        rd_idx = 4'd1;
        rd_rev = 1'b0;
        start_key(k);
        chk("b2b_key_valid_drop", 128'(key_valid), 128'd0);
        chk("b2b_rd_key_zero", rd_key, '0);
        wait_done("b2b_second", 0);
        check_reads("b2b_reads");

        // random keys
        for (int it = 0; it < 5; it++) begin
            @(posedge clk);
            #1;
            start_key({$urandom, $urandom, $urandom, $urandom});
            wait_done("rand", 0);
            check_reads("rand_reads");
        end

        @(negedge clk);
        #1 chk("final_stream_drained", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
